state_timer: RTL
================

STATE_TIMER -- requirements
Module: state_timer

Interface
REQ-001 Parameter TICK_DIV, default 50000; clk cycles per timer tick (1 ms at 50 MHz); legal range 2..65535.
REQ-002 Parameter TW, default 19; width of time values.
REQ-003 clk  input  1  single clock; all flops on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 present_state  input  4  controller state code, same signal that drives the time selector.
REQ-006 tout  input  TW  selected duration in ticks, valid in the same cycle as present_state; 0 = untimed state.
REQ-007 pause  input  1  while high, freezes prescaler and counter.
REQ-008 time_up  output  1  one-cycle pulse when the loaded duration expires.
REQ-009 busy  output  1  high while in RUN.
REQ-010 remaining  output  TW  current down-counter value.

Function
REQ-011 prev_state register holds present_state from the previous cycle; change = (present_state != prev_state).
REQ-012 FSM states are IDLE, RUN and DONE.
REQ-013 On any edge where change=1, in any FSM state: if tout!=0, counter<=tout, prescaler<=0, next state RUN; if tout==0, counter<=0, next state IDLE.
REQ-014 A load is visible on remaining and busy one cycle after the first edge on which the new present_state is sampled.
REQ-015 In RUN, with pause=0 and change=0, the prescaler increments each cycle and wraps to 0 after TICK_DIV-1. The wrap cycle is a tick.
REQ-016 On a tick in RUN: counter decrements by 1. If the counter was 1, counter becomes 0, time_up pulses high for exactly one cycle (the cycle after the edge), and the next state is DONE.
REQ-017 Expiry latency: time_up is asserted tout*TICK_DIV cycles after the load edge, given no pause and no change.
REQ-018 pause=1 holds both the prescaler and the counter; it never blocks a load.
REQ-019 If change and tick occur on the same edge, the load wins and the tick is discarded; time_up is not asserted.
REQ-020 DONE holds counter=0, busy=0 and time_up=0 until the next change.
REQ-021 IDLE holds counter=0 and ignores ticks; time_up is never asserted from IDLE.
REQ-022 The counter never underflows; a tick with counter==0 is impossible by construction and has no effect.
REQ-023 A change to a state whose tout equals the current remaining value still reloads and restarts the prescaler.

Reset
REQ-024 While rst_n=0: FSM=IDLE, prev_state=4'b0000, counter=0, prescaler=0, time_up=0, busy=0, remaining=0.
REQ-025 Reset asserted mid-RUN aborts the timing immediately, with no time_up pulse.
REQ-026 After rst_n deasserts, a nonzero present_state counts as a change on the first edge and loads per REQ-013.

Structure
REQ-027 A shared package holds: TW; the state codes 4'b0010 (T1 phase) and 4'b0011–4'b0101 (T0 phases); and the FSM encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
REQ-028 One sub-module, tick_gen, holds the prescaler with inputs clear, hold and output tick. state_timer owns the FSM and the counter.
REQ-029 Outputs are driven directly from registers, with no combinational path from inputs to outputs.

Verification (TICK_DIV=4)
REQ-030 Reset, then present_state 0000->0010 with tout=3 -> remaining=3 and busy=1 the next cycle; time_up is a single pulse 12 cycles after the load edge; then DONE with busy=0.
REQ-031 RUN with tout=5, pause high for 10 cycles midway -> time_up is delayed by exactly 10 cycles and remaining is frozen during the pause.
REQ-032 Change 0010->0011 (tout=7) on the same edge as a tick while remaining=1 -> no time_up, remaining=7, prescaler restarted.
REQ-033 Change to a state with tout=0 (e.g. 0110) while running -> IDLE, remaining=0, busy=0, no time_up for 100 cycles.
REQ-034 Assert rst_n=0 mid-RUN with remaining=4 -> all outputs 0 immediately (asynchronously), no pulse. Release rst_n with present_state=0011 and tout=2 -> load on the first edge.
REQ-035 Sit in DONE for 50 cycles, then change 0011->0100 with tout=1 -> time_up 4 cycles after the load edge.

Source files
------------

// File: rtl/state_timer_pkg.sv
// state_timer_pkg: shared width, controller state codes and timer FSM encoding
package state_timer_pkg;
  localparam int TW = 19;
  localparam logic [3:0] ST_T1   = 4'b0010;
  localparam logic [3:0] ST_T0_A = 4'b0011;
  localparam logic [3:0] ST_T0_B = 4'b0100;
  localparam logic [3:0] ST_T0_C = 4'b0101;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_e;
endpackage

// File: rtl/state_timer_if.sv
// state_timer_if: controller-to-timer bundle; master drives present_state/tout/pause, slave returns time_up/busy/remaining
interface state_timer_if #(parameter int TW = state_timer_pkg::TW);
  logic [3:0]    present_state;
  logic [TW-1:0] tout;
  logic          pause;
  logic          time_up;
  logic          busy;
  logic [TW-1:0] remaining;
  modport master (output present_state, tout, pause, input time_up, busy, remaining);
  modport slave (input present_state, tout, pause, output time_up, busy, remaining);
endinterface

// File: rtl/state_timer_tick_gen.sv
// tick_gen: prescaler emitting tick on the wrap cycle; ports clk, rst_n, clear_i (restart), hold_i (freeze), tick_o
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic hold_i,
  output logic tick_o
);
  logic [15:0] cnt_q, cnt_d;
  assign tick_o = !hold_i && cnt_q == 16'(TICK_DIV - 1);
  always_comb cnt_d = clear_i ? '0 : hold_i ? cnt_q : tick_o ? '0 : cnt_q + 16'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/state_timer.sv
// state_timer: per-state duration timer with load-on-change, pause and one-cycle time_up; ports clk, rst_n, bus (slave)
module state_timer
  import state_timer_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int TW       = state_timer_pkg::TW
) (
  input  logic          clk,
  input  logic          rst_n,
  state_timer_if.slave  bus
);
  logic [3:0]    prev_q;
  fsm_e          st_q, st_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          up_q, up_d, busy_q, busy_d;
  logic          change, tick;
  assign change = bus.present_state != prev_q;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(change),
    .hold_i (bus.pause || st_q != RUN),
    .tick_o (tick)
  );
  // a load on change always beats a coincident tick
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    up_d  = 1'b0;
    if (change) begin
      st_d  = (bus.tout != '0) ? RUN : IDLE;
      cnt_d = bus.tout;
    end else if (st_q == RUN && tick && cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
      up_d  = cnt_q == TW'(1);
      st_d  = (cnt_q == TW'(1)) ? DONE : RUN;
    end
    busy_d = st_d == RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_q <= '0;
      st_q   <= IDLE;
      cnt_q  <= '0;
      up_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      prev_q <= bus.present_state;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      up_q   <= up_d;
      busy_q <= busy_d;
    end
  assign bus.time_up   = up_q;
  assign bus.busy      = busy_q;
  assign bus.remaining = cnt_q;
endmodule
